id_decode_queue: RTL and testbench
==================================

# id_decode_queue

Registered, parametrised instruction-decode stage for the pipelined MIPS core, between instruction fetch and register read. Each accepted 32-bit instruction is split into its fields, classified, and immediate-extended. The decoded record is held in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a synchronous flush for branch/jump redirects.

## Interface
- DEPTH, 2, number of FIFO entries; power of two, ≥2
- EXT_W, 32, width of the extended immediate; ≥32
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous clear of all queued entries
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  32  address of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head this cycle
- out_op, out_func  output  6  instr[31:26], instr[5:0]
- out_rs, out_rt, out_rd, out_shamt  output  5  instr[25:21], [20:16], [15:11], [10:6]
- out_imm16  output  16  instr[15:0]
- out_imm_ext  output  EXT_W  extended immediate
- out_jidx  output  26  instr[25:0]
- out_class  output  3  instruction class
- out_pc  output  32  PC of head entry

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Decode is done at push time; the FIFO stores the full decoded record, not the raw word.
- in_ready = (count < DEPTH). No write-through when full, even if a pop occurs in the same cycle.
- out_valid = (count != 0). While empty, all out_* fields are zero.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Class codes:
  - R=0: op 0x00, except jr
  - IARITH=1: op 0x08–0x0e
  - LOAD=2: op 0x20–0x25
  - STORE=3: op 0x28–0x2b
  - BRANCH=4: op 0x04–0x07, 0x01
  - JUMP=5: op 0x02/0x03, or op 0x00 with func 0x08
  - LUI=6: op 0x0f
  - UNKNOWN=7: everything else
- Immediate extension:
  - andi/ori/xori (0x0c–0x0e): zero-extend to EXT_W.
  - LUI: {imm16, 16'b0}, sign-extended from bit 31 to EXT_W.
  - All others: sign-extend imm16 to EXT_W.
- flush: count and pointers go to 0 and any push in that cycle is dropped, so flush dominates push. in_ready is still computed from the pre-flush count.
- reset: identical effect to flush. It also zeroes the storage.

## Timing
- Latency: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N, if the queue was empty. No combinational path from in_* to out_*.
- out_* and out_valid depend only on registered state. in_ready depends only on count. No combinational path from out_ready to in_ready.
- Head fields stay stable while out_valid && !out_ready.
- After reset or flush: out_valid=0, in_ready=1, all outputs 0 on the following cycle.
- Sustained throughput: 1 instruction/cycle whenever count < DEPTH and downstream pops every cycle.

## Structure
- Package decode_pkg holds:
  - the class code localparams (CLS_R … CLS_UNKNOWN)
  - opcode and funct constants (OP_SPECIAL, OP_LUI, FN_JR, …)
  - the decoded-record field widths
- Sub-module instr_field_decode is purely combinational. It maps instr to fields, class and imm_ext, parametrised by EXT_W, and is instantiated once on the push path.
- The top level holds the storage array, pointers, count and handshake logic.

## Test plan
- Reset, then push ori $1,$0,0xFFFF (0x3401FFFF) with out_ready=1 -> next cycle out_valid=1, class=1, rt=1, imm_ext=0x0000FFFF; with EXT_W=64, upper 32 bits are 0.
- Push addiu 0x2401FFFF and lui 0x3C018000 with EXT_W=64 -> imm_ext 0xFFFF…FFFF, then 0xFFFFFFFF80000000, class=6.
- DEPTH=4, out_ready=0, push 5 instructions -> in_ready drops after the 4th. Then pop 4 -> same order, PCs intact, pointers wrap.
- Full queue with in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, count=3. Next cycle: push and pop together, count stays 3.
- Two entries queued, flush asserted with in_valid=1 -> next cycle out_valid=0, count=0, the pushed instruction never appears.
- Push jr $31 (0x03E00008) and an undefined op 0x3F -> class=5, then class=7. Assert reset mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants for the instruction-decode stage: class codes, MIPS
// opcode/funct values and the widths of the decoded-record fields.
package decode_pkg;

  // Decoded-record field widths
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JIDX_W  = 26;
  localparam int unsigned CLS_W   = 3;

  // Instruction classes
  localparam logic [CLS_W-1:0] CLS_R       = 3'd0;
  localparam logic [CLS_W-1:0] CLS_IARITH  = 3'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD    = 3'd2;
  localparam logic [CLS_W-1:0] CLS_STORE   = 3'd3;
  localparam logic [CLS_W-1:0] CLS_BRANCH  = 3'd4;
  localparam logic [CLS_W-1:0] CLS_JUMP    = 3'd5;
  localparam logic [CLS_W-1:0] CLS_LUI     = 3'd6;
  localparam logic [CLS_W-1:0] CLS_UNKNOWN = 3'd7;

  // Opcodes (range endpoints used for classification)
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0c;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0f;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2b;

  // Funct codes
  localparam logic [FN_W-1:0] FN_JR = 6'h08;

  // Decoded fields stored per queue entry (imm_ext and pc are kept separately
  // because imm_ext width is a parameter of the instantiating module)
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [FN_W-1:0]   func;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  imm16;
    logic [JIDX_W-1:0] jidx;
    logic [CLS_W-1:0]  cls;
  } dec_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational MIPS field splitter / classifier / immediate extender.
// Ports:
//   instr    - raw 32-bit instruction word
//   op..jidx - raw bit fields
//   cls      - instruction class code
//   imm_ext  - EXT_W-wide extended immediate
module instr_field_decode
  import decode_pkg::*;
#(
  parameter int unsigned EXT_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [FN_W-1:0]    func,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   shamt,
  output logic [IMM_W-1:0]   imm16,
  output logic [JIDX_W-1:0]  jidx,
  output logic [CLS_W-1:0]   cls,
  output logic [EXT_W-1:0]   imm_ext
);

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign func  = instr[5:0];
  assign imm16 = instr[15:0];
  assign jidx  = instr[25:0];

  always_comb begin
    cls = CLS_UNKNOWN;
    if (op == OP_SPECIAL) begin
      // jr is the only SPECIAL encoding treated as a jump
      cls = (func == FN_JR) ? CLS_JUMP : CLS_R;
    end else if (op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ)) begin
      cls = CLS_BRANCH;
    end else if (op == OP_J || op == OP_JAL) begin
      cls = CLS_JUMP;
    end else if (op >= OP_ADDI && op <= OP_XORI) begin
      cls = CLS_IARITH;
    end else if (op == OP_LUI) begin
      cls = CLS_LUI;
    end else if (op >= OP_LB && op <= OP_LHU) begin
      cls = CLS_LOAD;
    end else if (op >= OP_SB && op <= OP_SW) begin
      cls = CLS_STORE;
    end
  end

  // Fill upper bits first, then overlay the low bits; avoids zero-width
  // replications when EXT_W == 32.
  always_comb begin
    imm_ext = '0;
    if (op >= OP_ANDI && op <= OP_XORI) begin
      imm_ext[IMM_W-1:0] = imm16;
    end else if (op == OP_LUI) begin
      imm_ext       = {EXT_W{imm16[IMM_W-1]}};
      imm_ext[31:0] = {imm16, 16'h0000};
    end else begin
      imm_ext            = {EXT_W{imm16[IMM_W-1]}};
      imm_ext[IMM_W-1:0] = imm16;
    end
  end

endmodule

// File: rtl/id_decode_queue.sv
// Instruction-decode stage: decodes each accepted instruction at push time and
// holds the decoded record in a DEPTH-entry FIFO with valid/ready handshakes.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (also clears storage)
//   flush               - synchronous clear of all queued entries, dominates push
//   in_valid/in_ready   - fetch-side handshake; in_instr/in_pc are the payload
//   out_valid/out_ready - consumer-side handshake for the head entry
//   out_*               - decoded head fields; all zero while empty
module id_decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned EXT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [FN_W-1:0]    out_func,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_shamt,
  output logic [IMM_W-1:0]   out_imm16,
  output logic [EXT_W-1:0]   out_imm_ext,
  output logic [JIDX_W-1:0]  out_jidx,
  output logic [CLS_W-1:0]   out_class,
  output logic [PC_W-1:0]    out_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  dec_fields_t          dec;
  logic [EXT_W-1:0]     dec_ext;

  dec_fields_t          fields_q [DEPTH];
  logic [EXT_W-1:0]     ext_q    [DEPTH];
  logic [PC_W-1:0]      pc_q     [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;

  logic                 push;
  logic                 pop;
  dec_fields_t          head;

  instr_field_decode #(
    .EXT_W (EXT_W)
  ) u_decode (
    .instr   (in_instr),
    .op      (dec.op),
    .func    (dec.func),
    .rs      (dec.rs),
    .rt      (dec.rt),
    .rd      (dec.rd),
    .shamt   (dec.shamt),
    .imm16   (dec.imm16),
    .jidx    (dec.jidx),
    .cls     (dec.cls),
    .imm_ext (dec_ext)
  );

  // in_ready uses the current count only, so a same-cycle pop never frees a slot
  assign in_ready  = (count_q < DepthCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fields_q[i] <= '0;
        ext_q[i]    <= '0;
        pc_q[i]     <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fields_q[wr_ptr_q] <= dec;
        ext_q[wr_ptr_q]    <= dec_ext;
        pc_q[wr_ptr_q]     <= in_pc;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = fields_q[rd_ptr_q];
    end
  end

  assign out_op      = head.op;
  assign out_func    = head.func;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_imm16   = head.imm16;
  assign out_jidx    = head.jidx;
  assign out_class   = head.cls;
  assign out_imm_ext = out_valid ? ext_q[rd_ptr_q] : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_id_decode_queue.sv
module tb_id_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned EXT_W = 64;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_instr, in_pc, out_pc;
  logic [5:0]        out_op, out_func;
  logic [4:0]        out_rs, out_rt, out_rd, out_shamt;
  logic [15:0]       out_imm16;
  logic [EXT_W-1:0]  out_imm_ext;
  logic [25:0]       out_jidx;
  logic [2:0]        out_class;

  typedef struct {
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [63:0] ext;
    logic [25:0] jidx;
    logic [2:0]  cls;
    logic [31:0] pc;
  } rec_t;

  rec_t mq[$];
  int   total = 0;
  int   bad   = 0;

  id_decode_queue #(
    .DEPTH (DEPTH),
    .EXT_W (EXT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_func    (out_func),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_imm16   (out_imm16),
    .out_imm_ext (out_imm_ext),
    .out_jidx    (out_jidx),
    .out_class   (out_class),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // Reference decode straight from the class table and extension rules
  function automatic rec_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    rec_t r;
    int unsigned op, fn, imm;
    op = w[31:26];
    fn = w[5:0];
    imm = w[15:0];
    r.op = w[31:26]; r.func = w[5:0];
    r.rs = w[25:21]; r.rt = w[20:16]; r.rd = w[15:11]; r.shamt = w[10:6];
    r.imm16 = w[15:0]; r.jidx = w[25:0]; r.pc = pc;
    if (op == 0)                               r.cls = (fn == 8) ? 3'd5 : 3'd0;
    else if (op >= 8 && op <= 14)              r.cls = 3'd1;
    else if (op >= 32 && op <= 37)             r.cls = 3'd2;
    else if (op >= 40 && op <= 43)             r.cls = 3'd3;
    else if (op == 1 || (op >= 4 && op <= 7))  r.cls = 3'd4;
    else if (op == 2 || op == 3)               r.cls = 3'd5;
    else if (op == 15)                         r.cls = 3'd6;
    else                                       r.cls = 3'd7;
    if (op >= 12 && op <= 14) begin
      r.ext = 64'(imm);
    end else if (op == 15) begin
      r.ext = 64'(imm) * 64'd65536;
      if (imm >= 32768) r.ext = r.ext + 64'hFFFF_FFFF_0000_0000;
    end else begin
      r.ext = 64'(imm);
      if (imm >= 32768) r.ext = r.ext - 64'h1_0000;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    rec_t e;
    e = '{default: '0};
    if (mq.size() != 0) e = mq[0];
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("fields", 64'({out_op, out_func, out_rs, out_rt, out_rd, out_shamt}),
        64'({e.op, e.func, e.rs, e.rt, e.rd, e.shamt}));
    chk("imm16_jidx", 64'({out_imm16, out_jidx}), 64'({e.imm16, e.jidx}));
    chk("imm_ext", out_imm_ext, e.ext);
    chk("class", 64'(out_class), 64'(e.cls));
    chk("pc", 64'(out_pc), 64'(e.pc));
  endtask

  // Drive one cycle of inputs, check in_ready, clock, update model, check outputs
  task automatic tick(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rst);
    logic acc, pp;
    reset = rst; flush = fl; in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    acc = v && (mq.size() < DEPTH);
    pp  = rdy && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(model_decode(instr, pc));
    end
    check_outputs();
  endtask

  initial begin
    logic [5:0]  ops [16];
    logic [31:0] w;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09,
            6'h0c, 6'h0e, 6'h0f, 6'h20, 6'h25, 6'h28, 6'h2b, 6'h3f};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    tick(0, 32'h0, 32'h0, 0, 0, 1);
    // ori $1,$0,0xFFFF: zero-extended
    tick(1, 32'h3401FFFF, 32'h100, 1, 0, 0);
    tick(0, 32'h0, 32'h0, 1, 0, 0);
    // addiu / lui sign-extension
    tick(1, 32'h2401FFFF, 32'h104, 1, 0, 0);
    tick(1, 32'h3C018000, 32'h108, 1, 0, 0);
    tick(0, 32'h0, 32'h0, 1, 0, 0);
    // Fill with consumer stalled; 5th push refused
    for (int i = 0; i < 5; i++) tick(1, 32'h8C000000 + i, 32'h200 + 4 * i, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 32'h0, 32'h0, 1, 0, 0);
    // Full with push+pop: pop only; then push+pop together
    for (int i = 0; i < 4; i++) tick(1, 32'hAC000000 + i, 32'h300 + 4 * i, 0, 0, 0);
    tick(1, 32'h10000010, 32'h400, 1, 0, 0);
    tick(1, 32'h10000011, 32'h404, 1, 0, 0);
    tick(1, 32'h10000012, 32'h408, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 32'h0, 32'h0, 1, 0, 0);
    // Flush with a concurrent push
    tick(1, 32'h20010001, 32'h500, 0, 0, 0);
    tick(1, 32'h20010002, 32'h504, 0, 0, 0);
    tick(1, 32'h20010003, 32'h508, 0, 1, 0);
    tick(0, 32'h0, 32'h0, 1, 0, 0);
    // jr $31, undefined op, then reset mid-stream
    tick(1, 32'h03E00008, 32'h600, 0, 0, 0);
    tick(1, 32'hFC000000, 32'h604, 0, 0, 0);
    tick(0, 32'h0, 32'h0, 0, 0, 0);
    tick(1, 32'h0C000001, 32'h608, 1, 0, 1);
    tick(0, 32'h0, 32'h0, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[31:26] = ops[$urandom_range(15)];
      if (w[31:26] == 6'h00 && $urandom_range(3) == 0) w[5:0] = 6'h08;
      tick(1'($urandom_range(3) != 0), w, $urandom, 1'($urandom_range(2) != 0),
           1'($urandom_range(31) == 0), 1'($urandom_range(127) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
